// File: rtl/kolum_pkg.sv
// Shared types for the decode-stage hazard scoreboard.
//   REG_IDX_W  : width of an architectural register index
//   sb_entry_t : one tracked in-flight instruction
//   SB_BUBBLE  : empty slot value (all fields zero)
package kolum_pkg;

    localparam int REG_IDX_W = 4;

    typedef struct packed {
        logic                 valid;
        logic                 wb_en;
        logic                 mem_read;
        logic [REG_IDX_W-1:0] dest;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '{valid: 1'b0, wb_en: 1'b0, mem_read: 1'b0, dest: '0};

endpackage

// File: rtl/sb_match.sv
// RAW comparator for one scoreboard slot against the decode-stage sources.
//   i_slot     : tracked in-flight instruction
//   i_src1     : decode Rn,        i_use1 : Rn is actually read
//   i_src2     : decode Rm/Rd,     i_use2 : Rm/Rd is actually read
//   o_match    : slot writes a register the decode instruction reads
//   o_load_use : o_match and the slot is a load
module sb_match
    import kolum_pkg::*;
(
    input  sb_entry_t            i_slot,
    input  logic [REG_IDX_W-1:0] i_src1,
    input  logic [REG_IDX_W-1:0] i_src2,
    input  logic                 i_use1,
    input  logic                 i_use2,
    output logic                 o_match,
    output logic                 o_load_use
);

    logic w_live;
    logic w_hit1;
    logic w_hit2;

    assign w_live     = i_slot.valid & i_slot.wb_en;
    assign w_hit1     = i_use1 & (i_slot.dest == i_src1);
    assign w_hit2     = i_use2 & (i_slot.dest == i_src2);
    assign o_match    = w_live & (w_hit1 | w_hit2);
    assign o_load_use = o_match & i_slot.mem_read;

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks destinations of instructions between decode and write-back and
// requests a decode stall on read-after-write dependences.
//   clk, rst            : clock, async active-high reset
//   forward_en          : 1 = stall on load-use only, 0 = stall on any RAW
//   freeze_in           : memory stage busy, hold slots and counter
//   flush_in            : instruction in ID is killed, suppresses the stall
//   id_*                : decode-stage instruction attributes
//   hazard_out          : combinational stall request
//   stall_count_out     : saturating count of stall cycles
module hazard_scoreboard
    import kolum_pkg::*;
#(
    parameter int N_STAGES = 2,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 forward_en,
    input  logic                 freeze_in,
    input  logic                 flush_in,
    input  logic                 id_wb_enable_in,
    input  logic                 id_mem_read_in,
    input  logic                 id_branch_in,
    input  logic                 id_two_src_in,
    input  logic [REG_IDX_W-1:0] id_dest_in,
    input  logic [REG_IDX_W-1:0] id_src1_in,
    input  logic [REG_IDX_W-1:0] id_src2_in,
    output logic                 hazard_out,
    output logic [CNT_W-1:0]     stall_count_out
);

    // With forwarding, only a load still in EXE cannot supply its result.
    localparam logic [N_STAGES-1:0] FWD_STALL_SLOTS = N_STAGES'(1);

    sb_entry_t           r_slots [N_STAGES];
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [N_STAGES-1:0] w_match;
    logic [N_STAGES-1:0] w_load_use;
    logic                w_use1;
    logic                w_use2;
    logic                w_raw_hazard;
    sb_entry_t           w_new_slot;

    // A branch carries a register field in the Rn position that it never reads.
    assign w_use1 = ~id_branch_in;
    assign w_use2 = id_two_src_in;

    for (genvar g = 0; g < N_STAGES; g++) begin : g_match
        sb_match u_match (
            .i_slot     (r_slots[g]),
            .i_src1     (id_src1_in),
            .i_src2     (id_src2_in),
            .i_use1     (w_use1),
            .i_use2     (w_use2),
            .o_match    (w_match[g]),
            .o_load_use (w_load_use[g])
        );
    end

    assign w_raw_hazard = forward_en ? |(w_load_use & FWD_STALL_SLOTS) : |w_match;
    assign hazard_out   = w_raw_hazard & ~flush_in;

    // A stalled or killed decode instruction must not enter the pipeline.
    assign w_new_slot = (flush_in | hazard_out)
                      ? SB_BUBBLE
                      : '{valid: 1'b1, wb_en: id_wb_enable_in,
                          mem_read: id_mem_read_in, dest: id_dest_in};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_STAGES; k++) begin
                r_slots[k] <= SB_BUBBLE;
            end
        end else if (!freeze_in) begin
            for (int k = N_STAGES - 1; k > 0; k--) begin
                r_slots[k] <= r_slots[k-1];
            end
            r_slots[0] <= w_new_slot;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (hazard_out && !freeze_in && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_count_out = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       forward_en;
    logic       freeze_in;
    logic       flush_in;
    logic       id_wb_enable_in;
    logic       id_mem_read_in;
    logic       id_branch_in;
    logic       id_two_src_in;
    logic [3:0] id_dest_in;
    logic [3:0] id_src1_in;
    logic [3:0] id_src2_in;
    logic       hazard_out;
    logic [3:0] stall_count_out;

    always #5 clk = ~clk;

    hazard_scoreboard #(.N_STAGES(2), .CNT_W(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .forward_en      (forward_en),
        .freeze_in       (freeze_in),
        .flush_in        (flush_in),
        .id_wb_enable_in (id_wb_enable_in),
        .id_mem_read_in  (id_mem_read_in),
        .id_branch_in    (id_branch_in),
        .id_two_src_in   (id_two_src_in),
        .id_dest_in      (id_dest_in),
        .id_src1_in      (id_src1_in),
        .id_src2_in      (id_src2_in),
        .hazard_out      (hazard_out),
        .stall_count_out (stall_count_out)
    );

    typedef struct {
        logic       haz;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // reference model of the tracked slots (index 0 = EXE)
    logic       m_v  [2];
    logic       m_wb [2];
    logic       m_mr [2];
    logic [3:0] m_d  [2];
    logic [3:0] m_cnt;
    logic       last_haz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_v[i] = 1'b0; m_wb[i] = 1'b0; m_mr[i] = 1'b0; m_d[i] = 4'd0;
        end
        m_cnt = 4'd0;
    endtask

    function automatic logic model_haz();
        logic hit;
        logic any_hit;
        logic ld_hit;
        any_hit = 1'b0;
        ld_hit  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            hit = m_v[i] && m_wb[i] &&
                  ((!id_branch_in && (m_d[i] == id_src1_in)) ||
                   (id_two_src_in && (m_d[i] == id_src2_in)));
            if (hit) any_hit = 1'b1;
            if (hit && (i == 0) && m_mr[0]) ld_hit = 1'b1;
        end
        if (flush_in) return 1'b0;
        return forward_en ? ld_hit : any_hit;
    endfunction

    // One decode cycle: predict, compare at negedge, advance model at posedge.
    task automatic cyc(input string tag);
        exp_t e;
        exp_t got;
        @(negedge clk);
        e.haz = model_haz();
        e.cnt = m_cnt;
        sb_q.push_back(e);
        got = sb_q.pop_front();
        chk({tag, ".haz"}, 32'(hazard_out), 32'(got.haz));
        chk({tag, ".cnt"}, 32'(stall_count_out), 32'(got.cnt));
        last_haz = hazard_out;
        @(posedge clk);
        if (!freeze_in) begin
            if (e.haz && (m_cnt != 4'hF)) m_cnt = m_cnt + 4'd1;
            m_v[1] = m_v[0]; m_wb[1] = m_wb[0]; m_mr[1] = m_mr[0]; m_d[1] = m_d[0];
            if (flush_in || e.haz) begin
                m_v[0] = 1'b0; m_wb[0] = 1'b0; m_mr[0] = 1'b0; m_d[0] = 4'd0;
            end else begin
                m_v[0] = 1'b1; m_wb[0] = id_wb_enable_in;
                m_mr[0] = id_mem_read_in; m_d[0] = id_dest_in;
            end
        end
        #1;
    endtask

    task automatic issue(input logic wb, input logic mr, input logic br, input logic two,
                         input logic [3:0] dst, input logic [3:0] s1, input logic [3:0] s2,
                         input string tag);
        id_wb_enable_in = wb;
        id_mem_read_in  = mr;
        id_branch_in    = br;
        id_two_src_in   = two;
        id_dest_in      = dst;
        id_src1_in      = s1;
        id_src2_in      = s2;
        cyc(tag);
    endtask

    task automatic nop();
        issue(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, "nop");
    endtask

    task automatic alu(input logic [3:0] dst, input logic [3:0] s1, input logic [3:0] s2,
                       input string tag);
        issue(1'b1, 1'b0, 1'b0, 1'b1, dst, s1, s2, tag);
    endtask

    initial begin
        rst = 1'b1; forward_en = 1'b0; freeze_in = 1'b0; flush_in = 1'b0;
        id_wb_enable_in = 1'b0; id_mem_read_in = 1'b0; id_branch_in = 1'b1;
        id_two_src_in = 1'b0; id_dest_in = 4'd0; id_src1_in = 4'd0; id_src2_in = 4'd0;
        last_haz = 1'b0;
        model_reset();
        #1;
        chk("reset.haz", 32'(hazard_out), 32'd0);
        chk("reset.cnt", 32'(stall_count_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ALU producer directly ahead, no forwarding: two stall cycles
        alu(4'd1, 4'd8, 4'd9, "add_r1");
        alu(4'd2, 4'd1, 4'd3, "sub_a");   chk("nofwd.stall1", 32'(last_haz), 32'd1);
        alu(4'd2, 4'd1, 4'd3, "sub_b");   chk("nofwd.stall2", 32'(last_haz), 32'd1);
        alu(4'd2, 4'd1, 4'd3, "sub_c");   chk("nofwd.go", 32'(last_haz), 32'd0);
        chk("nofwd.cnt", 32'(stall_count_out), 32'd2);

        // forwarding: ALU pair free, load-use exactly one stall
        forward_en = 1'b1;
        nop(); nop();
        alu(4'd1, 4'd8, 4'd9, "fwd_add");
        alu(4'd2, 4'd1, 4'd3, "fwd_sub"); chk("fwd.alu_nostall", 32'(last_haz), 32'd0);
        issue(1'b1, 1'b1, 1'b0, 1'b0, 4'd4, 4'd10, 4'd0, "ldr_r4");
        alu(4'd5, 4'd4, 4'd0, "lu_a");    chk("fwd.load_stall", 32'(last_haz), 32'd1);
        alu(4'd5, 4'd4, 4'd0, "lu_b");    chk("fwd.load_go", 32'(last_haz), 32'd0);
        chk("fwd.cnt", 32'(stall_count_out), 32'd3);

        // src2 (store data) match; branch ignores src1
        forward_en = 1'b0;
        nop(); nop();
        issue(1'b1, 1'b0, 1'b0, 1'b1, 4'd6, 4'd12, 4'd11, "mov_r6");
        issue(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd7, 4'd6, "str_a"); chk("str.src2", 32'(last_haz), 32'd1);
        issue(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd7, 4'd6, "str_b");
        issue(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd7, 4'd6, "str_c"); chk("str.go", 32'(last_haz), 32'd0);
        nop(); nop();
        issue(1'b1, 1'b0, 1'b0, 1'b1, 4'd6, 4'd12, 4'd11, "mov_r6b");
        issue(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd6, 4'd0, "branch"); chk("br.src1_ignored", 32'(last_haz), 32'd0);

        // freeze during a pending hazard
        nop(); nop();
        alu(4'd1, 4'd8, 4'd9, "frz_add");
        freeze_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alu(4'd2, 4'd1, 4'd3, "frz_hold");
            chk("frz.haz_held", 32'(last_haz), 32'd1);
        end
        chk("frz.cnt_held", 32'(stall_count_out), 32'd5);
        freeze_in = 1'b0;
        alu(4'd2, 4'd1, 4'd3, "frz_r1");  chk("frz.rel1", 32'(last_haz), 32'd1);
        alu(4'd2, 4'd1, 4'd3, "frz_r2");  chk("frz.rel2", 32'(last_haz), 32'd1);
        alu(4'd2, 4'd1, 4'd3, "frz_r3");  chk("frz.rel_go", 32'(last_haz), 32'd0);
        chk("frz.cnt", 32'(stall_count_out), 32'd7);

        // flush wins over a hazard; killed destination is never tracked
        nop(); nop();
        alu(4'd1, 4'd8, 4'd9, "fl_add");
        flush_in = 1'b1;
        alu(4'd2, 4'd1, 4'd3, "fl_sub");  chk("flush.haz", 32'(last_haz), 32'd0);
        flush_in = 1'b0;
        alu(4'd3, 4'd2, 4'd2, "fl_orr");  chk("flush.bubble", 32'(last_haz), 32'd0);
        chk("flush.cnt", 32'(stall_count_out), 32'd7);

        // saturation of the 4-bit counter
        for (int i = 0; i < 5; i++) begin
            alu(4'd1, 4'd8, 4'd9, "sat_add");
            for (int j = 0; j < 3; j++) alu(4'd2, 4'd1, 4'd3, "sat_sub");
        end
        chk("sat.cnt", 32'(stall_count_out), 32'd15);

        // asynchronous reset in the middle of a stall
        alu(4'd1, 4'd8, 4'd9, "rst_add");
        alu(4'd2, 4'd1, 4'd3, "rst_sub"); chk("rst.pre_haz", 32'(last_haz), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst.async_haz", 32'(hazard_out), 32'd0);
        chk("rst.async_cnt", 32'(stall_count_out), 32'd0);
        model_reset();
        rst = 1'b0;
        alu(4'd2, 4'd1, 4'd3, "post_rst"); chk("rst.after", 32'(last_haz), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
